frame_seq_ctrl: RTL and testbench
=================================

# frame_seq_ctrl

Frame sequencer for the pixel pipeline. It watches the raw `vs_in`/`hs_in`/`de_in` timing at the pipeline input and generates per-pixel position and control for the line-buffered kernel datapath:
- pixel coordinates;
- line-buffer write enable and rotate strobe;
- window-valid;
- start-of-frame;
- frame counter.

The existing timing delay line keeps sync aligned at the pipeline output. This block drives the pipeline's front end.

## Interface
- `X_W`, 11, width of `x_pos` (max line length 2^X_W-1)
- `Y_W`, 11, width of `y_pos`
- `KERNEL`, 3, window size; `win_valid` requires `x_pos` and `y_pos` both ≥ KERNEL-1
- `FCNT_W`, 8, width of `frame_cnt`

Ports:
- `clk`  in  1  pipeline clock; single clock domain
- `reset`  in  1  synchronous, active-high
- `vs_in`  in  1  vertical sync, active-high
- `hs_in`  in  1  horizontal sync, active-high (monitored only)
- `de_in`  in  1  data enable, active-high
- `pix_valid`  out  1  registered copy of an accepted `de_in` cycle
- `x_pos`  out  X_W  column of current pixel
- `y_pos`  out  Y_W  active line index
- `lb_wr_en`  out  1  line-buffer write enable (= `pix_valid`)
- `lb_rot`  out  1  one-cycle pulse: rotate line buffers
- `win_valid`  out  1  full KERNEL×KERNEL window available
- `sof`  out  1  one-cycle pulse on pixel (0,0)
- `frame_cnt`  out  FCNT_W  completed-frame count, wraps
- `err_len`  out  1  line-length mismatch, sticky per frame

## Operation
- States: IDLE, VBLANK, ACTIVE, HBLANK.
- Edges are detected against a one-cycle registered copy of `vs_in` and `de_in`.
- IDLE is entered on reset. All `de_in` is ignored until the first `vs_in` rising edge, which moves to VBLANK.
- A `vs_in` rising edge in any non-IDLE state:
  - moves to VBLANK;
  - clears `y_pos` and `err_len`;
  - increments `frame_cnt` unless the previous state was IDLE or no line completed since the last `vs_in` rise.
- VBLANK/HBLANK + `de_in` high → ACTIVE. The x counter starts at 0.
- ACTIVE + `de_in` low → HBLANK. `lb_rot` pulses. The y counter increments, saturating at 2^Y_W-1.
- The x counter increments per `de_in`-high cycle and saturates at 2^X_W-1.
- `win_valid` = `pix_valid` && `x_pos` ≥ KERNEL-1 && `y_pos` ≥ KERNEL-1.
- `sof` = `pix_valid` && `x_pos`==0 && `y_pos`==0.
- Simultaneous `vs_in` rise and `de_in` high: the vs event wins. That pixel is counted as (0,0) of the new frame.
- `hs_in` does not affect state. It is reserved for the error monitor.

## Timing
- Latency: `de_in` high sampled at edge t → `pix_valid`/`x_pos`/`y_pos`/`lb_wr_en`/`win_valid`/`sof` valid after edge t+1.
- `lb_rot` is asserted for exactly the one cycle after the last `pix_valid` of a line. It never coincides with `pix_valid`.
- A line of N pixels gives N consecutive `pix_valid` cycles, with `x_pos` 0..N-1.
- Reset values:
  - all outputs 0;
  - state IDLE.
- Reset mid-line aborts immediately. No `lb_rot` is issued for the aborted line.
- `frame_cnt` wraps from 2^FCNT_W-1 to 0.

## Configuration
- `FRAME_SEQ_CTRL_ERR_EN` defined:
  - the length of line 0 of each frame is captured;
  - any later line of that frame with a different `de_in`-high count sets `err_len` in the `lb_rot` cycle of that line;
  - `err_len` holds until the next `vs_in` rise or reset;
  - `err_len` is also set if `hs_in` is high while `de_in` is high.
- Undefined: `err_len` is tied 0. No capture register is built.

## Test plan
- Reset, then 4 `de_in`-high cycles with no prior `vs_in` → `pix_valid` stays 0, state IDLE.
- `vs_in` pulse, then 3 lines of 5 pixels separated by 2 blank cycles:
  - `x_pos` 0..4 per line, `y_pos` 0,1,2;
  - `lb_rot` pulses 3 times, each one cycle after `x_pos`=4;
  - `sof` pulses only on (0,0).
- KERNEL=3, same frame → `win_valid` high only on line 2 at `x_pos` 2,3,4 (3 cycles total).
- 256 frames with FCNT_W=8 → `frame_cnt` reads 255 after frame 255's `vs_in` rise and wraps to 0 on the next.
- `vs_in` rise in the same cycle as `de_in` high mid-line → that pixel reports (0,0) with `sof`=1, and `y_pos` restarts.
- With `FRAME_SEQ_CTRL_ERR_EN`: lines of 5, 5, 4 pixels → `err_len` rises in the third `lb_rot` cycle and clears on the next `vs_in` rise. Without the macro, `err_len` stays 0.

Source files
------------

// File: rtl/frame_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : frame_seq_ctrl
//  Description : Frame sequencer for the line-buffered pixel pipeline front
//                end. Tracks vs_in/de_in timing and produces pixel
//                coordinates, line-buffer write/rotate strobes, window-valid,
//                start-of-frame, a wrapping completed-frame counter and an
//                optional line-length error flag.
//
//  Ports
//    clk        in   pipeline clock (single domain)
//    reset      in   synchronous, active-high
//    vs_in      in   vertical sync, active-high
//    hs_in      in   horizontal sync, active-high (error monitor only)
//    de_in      in   data enable, active-high
//    pix_valid  out  registered copy of an accepted de_in cycle
//    x_pos      out  column of current pixel            [X_W-1:0]
//    y_pos      out  active line index                  [Y_W-1:0]
//    lb_wr_en   out  line-buffer write enable (= pix_valid)
//    lb_rot     out  one-cycle pulse after the last pixel of a line
//    win_valid  out  full KERNEL x KERNEL window available
//    sof        out  one-cycle pulse on pixel (0,0)
//    frame_cnt  out  completed-frame count, wraps       [FCNT_W-1:0]
//    err_len    out  line-length / hs-during-de error, sticky per frame
//
//  Build option
//    FRAME_SEQ_CTRL_ERR_EN : when defined, builds the line-length capture and
//                            error monitor; otherwise err_len is tied 0.
//
//  Revision    : 1.0  initial release
// ============================================================================
module frame_seq_ctrl #(
    parameter int X_W    = 11,
    parameter int Y_W    = 11,
    parameter int KERNEL = 3,
    parameter int FCNT_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              vs_in,
    input  logic              hs_in,
    input  logic              de_in,
    output logic              pix_valid,
    output logic [X_W-1:0]    x_pos,
    output logic [Y_W-1:0]    y_pos,
    output logic              lb_wr_en,
    output logic              lb_rot,
    output logic              win_valid,
    output logic              sof,
    output logic [FCNT_W-1:0] frame_cnt,
    output logic              err_len
);

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_VBLANK = 2'd1;
    localparam logic [1:0] c_ST_ACTIVE = 2'd2;
    localparam logic [1:0] c_ST_HBLANK = 2'd3;

    localparam logic [X_W-1:0] c_X_MAX = {X_W{1'b1}};
    localparam logic [Y_W-1:0] c_Y_MAX = {Y_W{1'b1}};
    localparam logic [X_W-1:0] c_KX    = X_W'(KERNEL - 1);
    localparam logic [Y_W-1:0] c_KY    = Y_W'(KERNEL - 1);

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic              r_vs_d;
    logic              r_de_d;
    logic              r_line_done;

    logic              w_vs_rise;
    logic              w_pix_acc;
    logic              w_line_end;

    logic              w_pix_valid_nxt;
    logic [X_W-1:0]    w_x_nxt;
    logic [Y_W-1:0]    w_y_nxt;
    logic              w_rot_nxt;
    logic              w_win_nxt;
    logic              w_sof_nxt;
    logic [FCNT_W-1:0] w_fcnt_nxt;
    logic              w_line_done_nxt;

    // ------------------------------------------------------------------
    // Event decode
    // ------------------------------------------------------------------
    assign w_vs_rise  = vs_in & ~r_vs_d;
    // A pixel is accepted once out of IDLE; the vs rise cycle itself also
    // accepts its pixel as (0,0) of the new frame.
    assign w_pix_acc  = de_in & ((r_state != c_ST_IDLE) | w_vs_rise);
    // End of line: de falls while active. A simultaneous vs rise aborts the
    // line instead, so no rotate is issued for it.
    assign w_line_end = (r_state == c_ST_ACTIVE) & r_de_d & ~de_in & ~w_vs_rise;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        if (w_vs_rise) begin
            w_state_nxt = de_in ? c_ST_ACTIVE : c_ST_VBLANK;
        end else begin
            case (r_state)
                c_ST_IDLE:   w_state_nxt = c_ST_IDLE;
                c_ST_VBLANK,
                c_ST_HBLANK: if (de_in)  w_state_nxt = c_ST_ACTIVE;
                c_ST_ACTIVE: if (!de_in) w_state_nxt = c_ST_HBLANK;
                default:     w_state_nxt = c_ST_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output logic (next values of the registered outputs)
    // ------------------------------------------------------------------
    always_comb begin
        w_pix_valid_nxt = w_pix_acc;
        w_x_nxt         = x_pos;
        w_y_nxt         = y_pos;
        w_rot_nxt       = w_line_end;
        w_fcnt_nxt      = frame_cnt;
        w_line_done_nxt = r_line_done;

        if (w_pix_acc) begin
            // First pixel of a line (or of a new frame) restarts the column
            if (w_vs_rise || (r_state != c_ST_ACTIVE)) begin
                w_x_nxt = '0;
            end else if (x_pos != c_X_MAX) begin
                w_x_nxt = x_pos + X_W'(1);
            end
        end

        if (w_vs_rise) begin
            w_y_nxt         = '0;
            w_line_done_nxt = 1'b0;
            // Count a frame only if it actually produced a completed line
            if ((r_state != c_ST_IDLE) && r_line_done) begin
                w_fcnt_nxt = frame_cnt + FCNT_W'(1);
            end
        end else if (w_line_end) begin
            w_line_done_nxt = 1'b1;
            if (y_pos != c_Y_MAX) begin
                w_y_nxt = y_pos + Y_W'(1);
            end
        end

        w_win_nxt = w_pix_acc && (w_x_nxt >= c_KX) && (w_y_nxt >= c_KY);
        w_sof_nxt = w_pix_acc && (w_x_nxt == '0) && (w_y_nxt == '0);
    end

    // ------------------------------------------------------------------
    // Output / datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_vs_d      <= 1'b0;
            r_de_d      <= 1'b0;
            r_line_done <= 1'b0;
            pix_valid   <= 1'b0;
            x_pos       <= '0;
            y_pos       <= '0;
            lb_rot      <= 1'b0;
            win_valid   <= 1'b0;
            sof         <= 1'b0;
            frame_cnt   <= '0;
        end else begin
            r_vs_d      <= vs_in;
            r_de_d      <= de_in;
            r_line_done <= w_line_done_nxt;
            pix_valid   <= w_pix_valid_nxt;
            x_pos       <= w_x_nxt;
            y_pos       <= w_y_nxt;
            lb_rot      <= w_rot_nxt;
            win_valid   <= w_win_nxt;
            sof         <= w_sof_nxt;
            frame_cnt   <= w_fcnt_nxt;
        end
    end

    assign lb_wr_en = pix_valid;

    // ------------------------------------------------------------------
    // Line-length error monitor
    // ------------------------------------------------------------------
`ifdef FRAME_SEQ_CTRL_ERR_EN
    // Line lengths are held as the last column index (length - 1), which is
    // exactly what x_pos shows while the line-end is being decoded.
    logic [X_W-1:0] r_len0;
    logic           r_err;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_len0 <= '0;
            r_err  <= 1'b0;
        end else if (w_vs_rise) begin
            r_err  <= 1'b0;
        end else begin
            if (w_line_end) begin
                if (y_pos == '0) begin
                    r_len0 <= x_pos;
                end else if (x_pos != r_len0) begin
                    r_err  <= 1'b1;
                end
            end
            if (w_pix_acc && hs_in) begin
                r_err <= 1'b1;
            end
        end
    end

    assign err_len = r_err;
`else
    logic w_unused_hs;

    assign w_unused_hs = hs_in;
    assign err_len     = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_frame_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_frame_seq_ctrl
//  Description : Directed self-checking bench for frame_seq_ctrl.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_frame_seq_ctrl;

    localparam int X_W    = 11;
    localparam int Y_W    = 11;
    localparam int KERNEL = 3;
    localparam int FCNT_W = 8;

`ifdef FRAME_SEQ_CTRL_ERR_EN
    localparam bit c_ERR = 1'b1;
`else
    localparam bit c_ERR = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic              vs_in;
    logic              hs_in;
    logic              de_in;
    logic              pix_valid;
    logic [X_W-1:0]    x_pos;
    logic [Y_W-1:0]    y_pos;
    logic              lb_wr_en;
    logic              lb_rot;
    logic              win_valid;
    logic              sof;
    logic [FCNT_W-1:0] frame_cnt;
    logic              err_len;

    int compared   = 0;
    int mismatched = 0;
    int ey         = 0;
    int win_cnt    = 0;

    frame_seq_ctrl #(
        .X_W    (X_W),
        .Y_W    (Y_W),
        .KERNEL (KERNEL),
        .FCNT_W (FCNT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .vs_in     (vs_in),
        .hs_in     (hs_in),
        .de_in     (de_in),
        .pix_valid (pix_valid),
        .x_pos     (x_pos),
        .y_pos     (y_pos),
        .lb_wr_en  (lb_wr_en),
        .lb_rot    (lb_rot),
        .win_valid (win_valid),
        .sof       (sof),
        .frame_cnt (frame_cnt),
        .err_len   (err_len)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One active line of n pixels followed by two blank cycles.
    task automatic do_line(input int n, input bit exp_err);
        for (int i = 0; i < n; i++) begin
            de_in = 1'b1;
            step();
            chk("pix_valid", pix_valid, 1);
            chk("lb_wr_en", lb_wr_en, 1);
            chk("x_pos", x_pos, i);
            chk("y_pos", y_pos, ey);
            chk("sof", sof, (i == 0 && ey == 0));
            chk("win_valid", win_valid, (i >= KERNEL - 1 && ey >= KERNEL - 1));
            chk("lb_rot_in_line", lb_rot, 0);
            if (win_valid) win_cnt++;
        end
        de_in = 1'b0;
        step();
        chk("lb_rot", lb_rot, 1);
        chk("pv_at_rot", pix_valid, 0);
        chk("err_len_at_rot", err_len, exp_err);
        ey++;
        step();
        chk("lb_rot_off", lb_rot, 0);
    endtask

    task automatic vs_pulse(input int exp_fcnt);
        vs_in = 1'b1;
        step();
        chk("frame_cnt", frame_cnt, exp_fcnt);
        chk("err_len_vs", err_len, 0);
        chk("y_pos_vs", y_pos, 0);
        chk("pv_vs", pix_valid, 0);
        vs_in = 1'b0;
        step();
        ey = 0;
    endtask

    initial begin
        reset = 1'b1;
        vs_in = 1'b0;
        hs_in = 1'b0;
        de_in = 1'b0;
        step();
        step();
        reset = 1'b0;

        // Reset state
        chk("rst_pix_valid", pix_valid, 0);
        chk("rst_x_pos", x_pos, 0);
        chk("rst_y_pos", y_pos, 0);
        chk("rst_lb_wr_en", lb_wr_en, 0);
        chk("rst_lb_rot", lb_rot, 0);
        chk("rst_win_valid", win_valid, 0);
        chk("rst_sof", sof, 0);
        chk("rst_frame_cnt", frame_cnt, 0);
        chk("rst_err_len", err_len, 0);

        // de_in ignored while idle
        de_in = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("idle_pix_valid", pix_valid, 0);
        end
        de_in = 1'b0;
        step();

        // Frame A: 3 lines of 5 pixels
        vs_pulse(0);
        step();
        win_cnt = 0;
        do_line(5, 1'b0);
        do_line(5, 1'b0);
        do_line(5, 1'b0);
        chk("win_cnt", win_cnt, 3);

        // Frame B: 5, 5, 4 pixels -> length error on third line
        vs_pulse(1);
        do_line(5, 1'b0);
        do_line(5, 1'b0);
        do_line(4, c_ERR);
        chk("err_len_hold", err_len, c_ERR);

        // Frame C: vs rise mid-line with de high
        vs_pulse(2);
        do_line(5, 1'b0);
        for (int i = 0; i < 3; i++) begin
            de_in = 1'b1;
            step();
            chk("pre_vs_x", x_pos, i);
            chk("pre_vs_y", y_pos, 1);
        end
        vs_in = 1'b1;
        step();
        chk("vsde_pix_valid", pix_valid, 1);
        chk("vsde_x", x_pos, 0);
        chk("vsde_y", y_pos, 0);
        chk("vsde_sof", sof, 1);
        chk("vsde_fcnt", frame_cnt, 3);
        chk("vsde_rot", lb_rot, 0);
        vs_in = 1'b0;
        step();
        chk("vsde_x1", x_pos, 1);
        chk("vsde_sof1", sof, 0);
        step();
        chk("vsde_x2", x_pos, 2);
        de_in = 1'b0;
        step();
        chk("vsde_rot_end", lb_rot, 1);
        ey = 1;
        step();
        // Line 0 of this frame was 3 pixels; a 1-pixel line mismatches
        do_line(1, c_ERR);
        vs_pulse(4);

        // Frame counter up to 255 and wrap
        for (int k = 5; k <= 255; k++) begin
            do_line(1, 1'b0);
            vs_pulse(k);
        end
        do_line(1, 1'b0);
        vs_pulse(0);
        // No completed line since the last vs rise -> no increment
        vs_pulse(0);

        // hs during de
        de_in = 1'b1;
        hs_in = 1'b1;
        step();
        chk("hs_pix_valid", pix_valid, 1);
        chk("hs_err_len", err_len, c_ERR);
        hs_in = 1'b0;
        de_in = 1'b0;
        step();
        step();

        // Reset mid-line aborts without rotate
        de_in = 1'b1;
        step();
        step();
        chk("mid_x", x_pos, 1);
        reset = 1'b1;
        step();
        chk("mrst_pix_valid", pix_valid, 0);
        chk("mrst_x_pos", x_pos, 0);
        chk("mrst_err_len", err_len, 0);
        reset = 1'b0;
        de_in = 1'b0;
        step();
        chk("mrst_rot", lb_rot, 0);
        de_in = 1'b1;
        step();
        chk("mrst_idle_pv", pix_valid, 0);
        step();
        chk("mrst_idle_pv2", pix_valid, 0);
        de_in = 1'b0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire
